// File: rtl/buzzer_pkg.sv
// Shared definitions for the buzzer tone generator: register map, CTRL bit
// positions and the sequencing FSM state encoding.
package buzzer_pkg;

    localparam logic [1:0] ADDR_HALF_PERIOD = 2'd0;
    localparam logic [1:0] ADDR_ON_MS       = 2'd1;
    localparam logic [1:0] ADDR_OFF_MS      = 2'd2;
    localparam logic [1:0] ADDR_CTRL        = 2'd3;

    localparam int CTRL_REPEAT   = 0;
    localparam int CTRL_BUSY     = 1;
    localparam int CTRL_BUZZ     = 2;
    localparam int CTRL_IRQ      = 3;
    localparam int CTRL_IRQ_MASK = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } buzz_state_t;

endpackage

// File: rtl/buzzer_ms_timer.sv
// Millisecond timer: a prescaler producing one tick per ms and a loadable
// down-counter that flags expiry on the tick that takes it from 1 to 0.
module buzzer_ms_timer #(
    parameter int CLK_HZ = 50000000,
    parameter int DUR_W  = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [DUR_W-1:0] load_val,
    input  logic             run,
    output logic             tick,
    output logic             expire
);

    localparam int TICK_CLKS = CLK_HZ / 1000;
    localparam int PRE_W     = (TICK_CLKS > 1) ? $clog2(TICK_CLKS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CLKS - 1);

    logic [PRE_W-1:0] pre_cnt;
    logic [DUR_W-1:0] ms_cnt;

    assign tick   = run & (pre_cnt == PRE_LAST);
    // A loaded value of 0 never reaches the terminal count, so it runs forever.
    assign expire = tick & (ms_cnt == DUR_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= '0;
            ms_cnt  <= '0;
        end else if (load) begin
            pre_cnt <= '0;
            ms_cnt  <= load_val;
        end else if (run) begin
            pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
            if (tick && (ms_cnt != '0))
                ms_cnt <= ms_cnt - DUR_W'(1);
        end
    end

endmodule

// File: rtl/buzzer_tone_gen.sv
// Buzzer tone generator: Avalon-MM configured square-wave source with optional
// on/off cadence. Define BUZZER_TONE_IRQ_EN to add the one-shot completion irq.
//
// state | meaning
// IDLE  | silent, waiting for a rising edge on enable
// ON    | tone running, ms timer counting ON_MS
// OFF   | silent gap of a repeating cadence, ms timer counting OFF_MS
module buzzer_tone_gen
    import buzzer_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int DIV_W  = 20,
    parameter int DUR_W  = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        enable,
    output logic        buzzer_out,
    output logic        busy
`ifdef BUZZER_TONE_IRQ_EN
    ,
    output logic        irq
`endif
);

    logic [DIV_W-1:0] half_period;
    logic [DUR_W-1:0] on_ms;
    logic [DUR_W-1:0] off_ms;
    logic             repeat_en;

    buzz_state_t state, state_d;
    logic        en_q;
    logic        rise;
    logic        wr;

    logic             tmr_load;
    logic [DUR_W-1:0] tmr_val;
    logic             tmr_expire;
    logic             ms_tick_unused;
    logic             tone_start;

    logic [DIV_W-1:0] div_cnt, div_d;
    logic [DIV_W-1:0] hp_act, hp_act_d;
    logic             phase, phase_d;
    logic             boundary;
    logic             buzz_d;
    logic             irq_set;
    logic [31:0]      ctrl_word;
    logic             unused_wd;

    assign wr        = chipselect & ~write_n;
    assign rise      = enable & ~en_q;
    assign busy      = (state != IDLE);
    assign unused_wd = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            half_period <= '0;
            on_ms       <= '0;
            off_ms      <= '0;
            repeat_en   <= 1'b0;
        end else if (wr) begin
            case (address)
                ADDR_HALF_PERIOD: half_period <= writedata[DIV_W-1:0];
                ADDR_ON_MS:       on_ms       <= writedata[DUR_W-1:0];
                ADDR_OFF_MS:      off_ms      <= writedata[DUR_W-1:0];
                default:          repeat_en   <= writedata[CTRL_REPEAT];
            endcase
        end
    end

    buzzer_ms_timer #(
        .CLK_HZ (CLK_HZ),
        .DUR_W  (DUR_W)
    ) u_ms_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .run      (busy),
        .tick     (ms_tick_unused),
        .expire   (tmr_expire)
    );

    // Dropping enable takes priority over any timer expiry in the same cycle.
    always_comb begin
        state_d    = state;
        tmr_load   = 1'b0;
        tmr_val    = on_ms;
        tone_start = 1'b0;
        irq_set    = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_d    = ON;
                    tmr_load   = 1'b1;
                    tone_start = 1'b1;
                end
            end
            ON: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (tmr_expire) begin
                    if (!repeat_en) begin
                        state_d = IDLE;
                        irq_set = 1'b1;
                    end else if (off_ms != '0) begin
                        state_d  = OFF;
                        tmr_load = 1'b1;
                        tmr_val  = off_ms;
                    end else begin
                        tmr_load   = 1'b1;
                        tone_start = 1'b1;
                    end
                end
            end
            OFF: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (tmr_expire) begin
                    state_d    = ON;
                    tmr_load   = 1'b1;
                    tone_start = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // With a zero shadow every cycle is a boundary, so a later non-zero write
    // is picked up immediately instead of being stuck behind a dead divider.
    assign boundary = (hp_act == '0) | (div_cnt == hp_act - DIV_W'(1));

    always_comb begin
        div_d    = div_cnt;
        hp_act_d = hp_act;
        phase_d  = phase;
        if (tone_start) begin
            div_d    = '0;
            hp_act_d = half_period;
            phase_d  = 1'b1;
        end else if (state == ON) begin
            if (boundary) begin
                div_d    = '0;
                hp_act_d = half_period;
                if (hp_act != '0)
                    phase_d = ~phase;
            end else begin
                div_d = div_cnt + DIV_W'(1);
            end
        end
    end

    assign buzz_d = phase_d & (state_d == ON) & (hp_act_d != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            en_q       <= 1'b0;
            div_cnt    <= '0;
            hp_act     <= '0;
            phase      <= 1'b0;
            buzzer_out <= 1'b0;
        end else begin
            state      <= state_d;
            en_q       <= enable;
            div_cnt    <= div_d;
            hp_act     <= hp_act_d;
            phase      <= phase_d;
            buzzer_out <= buzz_d;
        end
    end

`ifdef BUZZER_TONE_IRQ_EN
    logic irq_flag;
    logic irq_mask;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_flag <= 1'b0;
            irq_mask <= 1'b0;
        end else begin
            if (irq_set)
                irq_flag <= 1'b1;
            else if (wr && (address == ADDR_CTRL))
                irq_flag <= 1'b0;
            if (wr && (address == ADDR_CTRL))
                irq_mask <= writedata[CTRL_IRQ_MASK];
        end
    end

    assign irq = irq_flag & irq_mask;
`endif

    always_comb begin
        ctrl_word              = '0;
        ctrl_word[CTRL_REPEAT] = repeat_en;
        ctrl_word[CTRL_BUSY]   = busy;
        ctrl_word[CTRL_BUZZ]   = buzzer_out;
`ifdef BUZZER_TONE_IRQ_EN
        ctrl_word[CTRL_IRQ]      = irq_flag;
        ctrl_word[CTRL_IRQ_MASK] = irq_mask;
`else
        ctrl_word[CTRL_IRQ]      = irq_set & 1'b0;
`endif
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_HALF_PERIOD: readdata = 32'(half_period);
            ADDR_ON_MS:       readdata = 32'(on_ms);
            ADDR_OFF_MS:      readdata = 32'(off_ms);
            default:          readdata = ctrl_word;
        endcase
    end

endmodule

// File: tb/tb_buzzer_tone_gen.sv
// Directed bench for buzzer_tone_gen at CLK_HZ=10000 (1 ms = 10 clocks).
// Define BUZZER_TONE_IRQ_EN to also exercise the irq port.
module tb_buzzer_tone_gen;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        enable = 1'b0;
    logic        buzzer_out;
    logic        busy;
`ifdef BUZZER_TONE_IRQ_EN
    logic        irq;
`endif

    int checks = 0;
    int failures = 0;

    buzzer_tone_gen #(
        .CLK_HZ (10000),
        .DIV_W  (20),
        .DUR_W  (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .enable     (enable),
        .buzzer_out (buzzer_out),
        .busy       (busy)
`ifdef BUZZER_TONE_IRQ_EN
        ,
        .irq        (irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        enable  = 1'b1;
        #1;
        checks++;
        if (buzzer_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_buzz got=%b want=0", buzzer_out);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b want=0", busy);
        end
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            #1;
            checks++;
            if (readdata !== 32'd0) begin
                failures++;
                $display("FAIL reset_rd addr=%0d got=%h want=0", a, readdata);
            end
        end
        step();
        step();
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            checks++;
            if (buzzer_out !== 1'b0) begin
                failures++;
                $display("FAIL post_reset_silent k=%0d got=%b want=0", k, buzzer_out);
            end
        end
        enable = 1'b0;
        step();
        step();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle busy got=%b want=0", busy);
        end
    endtask

    task automatic test_regs();
        logic [31:0] exp_ctrl;
        wr_reg(2'd0, 32'hFFFF_FFFF);
        wr_reg(2'd1, 32'hFFFF_FFFF);
        wr_reg(2'd2, 32'h1234_5678);
        wr_reg(2'd3, 32'hFFFF_FFFF);
`ifdef BUZZER_TONE_IRQ_EN
        exp_ctrl = 32'h0000_0011;
`else
        exp_ctrl = 32'h0000_0001;
`endif
        address = 2'd0; #1;
        checks++;
        if (readdata !== 32'h000F_FFFF) begin
            failures++;
            $display("FAIL rd_half_period got=%h want=000fffff", readdata);
        end
        address = 2'd1; #1;
        checks++;
        if (readdata !== 32'h0000_FFFF) begin
            failures++;
            $display("FAIL rd_on_ms got=%h want=0000ffff", readdata);
        end
        address = 2'd2; #1;
        checks++;
        if (readdata !== 32'h0000_5678) begin
            failures++;
            $display("FAIL rd_off_ms got=%h want=00005678", readdata);
        end
        address = 2'd3; #1;
        checks++;
        if (readdata !== exp_ctrl) begin
            failures++;
            $display("FAIL rd_ctrl got=%h want=%h", readdata, exp_ctrl);
        end
        for (int a = 0; a < 4; a++) wr_reg(2'(a), 32'd0);
    endtask

    task automatic test_continuous();
        logic exp;
        wr_reg(2'd0, 32'd3);
        wr_reg(2'd1, 32'd0);
        wr_reg(2'd3, 32'd0);
        enable = 1'b1;
        step();
        for (int k = 0; k < 12; k++) begin
            exp = ((k / 3) % 2) == 0;
            checks++;
            if (buzzer_out !== exp) begin
                failures++;
                $display("FAIL cont_tone k=%0d got=%b want=%b", k, buzzer_out, exp);
            end
            step();
        end
        enable = 1'b0;
        step();
        checks++;
        if (buzzer_out !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL cont_stop buzz=%b busy=%b want=0/0", buzzer_out, busy);
        end
    endtask

    task automatic test_one_shot();
        logic exp;
        int busy_cnt = 0;
        int high_cnt = 0;
        wr_reg(2'd0, 32'd2);
        wr_reg(2'd1, 32'd5);
        wr_reg(2'd3, 32'd0);
        enable = 1'b1;
        step();
        for (int k = 0; k < 70; k++) begin
            exp = (k < 50) && (((k / 2) % 2) == 0);
            if (busy === 1'b1) busy_cnt++;
            if (buzzer_out === 1'b1) high_cnt++;
            checks++;
            if (buzzer_out !== exp || busy !== (k < 50)) begin
                failures++;
                $display("FAIL one_shot k=%0d buzz=%b busy=%b want=%b/%b",
                         k, buzzer_out, busy, exp, (k < 50));
            end
            step();
        end
        checks++;
        if (busy_cnt != 50 || high_cnt != 26) begin
            failures++;
            $display("FAIL one_shot_len busy_clks=%0d high_clks=%0d want=50/26", busy_cnt, high_cnt);
        end
        enable = 1'b0;
        step();
        enable = 1'b1;
        step();
        checks++;
        if (busy !== 1'b1 || buzzer_out !== 1'b1) begin
            failures++;
            $display("FAIL one_shot_rearm busy=%b buzz=%b want=1/1", busy, buzzer_out);
        end
        enable = 1'b0;
        step();
    endtask

    task automatic test_cadence();
        logic exp;
        int m;
        wr_reg(2'd0, 32'd3);
        wr_reg(2'd1, 32'd2);
        wr_reg(2'd2, 32'd3);
        wr_reg(2'd3, 32'd1);
        enable = 1'b1;
        step();
        for (int k = 0; k < 100; k++) begin
            m = k % 50;
            exp = (m < 20) && (((m / 3) % 2) == 0);
            checks++;
            if (buzzer_out !== exp || busy !== 1'b1) begin
                failures++;
                $display("FAIL cadence k=%0d buzz=%b busy=%b want=%b/1", k, buzzer_out, busy, exp);
            end
            step();
        end
        enable = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL cadence_stop busy=%b want=0", busy);
        end
    endtask

    task automatic test_back_to_back();
        logic exp;
        int m;
        wr_reg(2'd2, 32'd0);
        enable = 1'b1;
        step();
        for (int k = 0; k < 45; k++) begin
            m = k % 20;
            exp = ((m / 3) % 2) == 0;
            checks++;
            if (buzzer_out !== exp || busy !== 1'b1) begin
                failures++;
                $display("FAIL back_to_back k=%0d buzz=%b busy=%b want=%b/1", k, buzzer_out, busy, exp);
            end
            step();
        end
        enable = 1'b0;
        step();
    endtask

    task automatic test_freq_change();
        logic exp;
        wr_reg(2'd0, 32'd4);
        wr_reg(2'd1, 32'd0);
        wr_reg(2'd3, 32'd0);
        enable = 1'b1;
        step();
        for (int k = 0; k < 46; k++) begin
            if (k < 4)       exp = 1'b1;
            else if (k < 32) exp = (((k - 4) / 7) % 2) == 1;
            else             exp = 1'b0;
            checks++;
            if (buzzer_out !== exp || busy !== 1'b1) begin
                failures++;
                $display("FAIL freq_change k=%0d buzz=%b busy=%b want=%b/1", k, buzzer_out, busy, exp);
            end
            address    = 2'd0;
            writedata  = (k == 1) ? 32'd7 : 32'd0;
            chipselect = (k == 1) || (k == 26);
            write_n    = !chipselect;
            step();
        end
        chipselect = 1'b0;
        write_n    = 1'b1;
        enable     = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        wr_reg(2'd0, 32'd3);
        wr_reg(2'd1, 32'd0);
        enable = 1'b1;
        step();
        checks++;
        if (buzzer_out !== 1'b1) begin
            failures++;
            $display("FAIL async_pre buzz=%b want=1", buzzer_out);
        end
        #2;
        reset_n = 1'b0;
        address = 2'd0;
        #1;
        checks++;
        if (buzzer_out !== 1'b0 || busy !== 1'b0 || readdata !== 32'd0) begin
            failures++;
            $display("FAIL async_reset buzz=%b busy=%b rd=%h want=0/0/0", buzzer_out, busy, readdata);
        end
        enable  = 1'b0;
        reset_n = 1'b1;
        step();
        step();
    endtask

`ifdef BUZZER_TONE_IRQ_EN
    task automatic test_irq();
        wr_reg(2'd0, 32'd2);
        wr_reg(2'd1, 32'd1);
        wr_reg(2'd3, 32'h10);
        enable = 1'b1;
        step();
        for (int k = 0; k < 12; k++) begin
            checks++;
            if (irq !== (k >= 10)) begin
                failures++;
                $display("FAIL irq_set k=%0d got=%b want=%b", k, irq, (k >= 10));
            end
            step();
        end
        address = 2'd3; #1;
        checks++;
        if (readdata[4:3] !== 2'b11) begin
            failures++;
            $display("FAIL irq_ctrl_rd got=%b want=11", readdata[4:3]);
        end
        wr_reg(2'd3, 32'h10);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_clear got=%b want=0", irq);
        end
        enable = 1'b0;
        step();
        enable = 1'b1;
        step();
        for (int k = 0; k < 9; k++) step();
        wr_reg(2'd3, 32'h10);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL irq_set_wins got=%b want=1", irq);
        end
        enable = 1'b0;
        wr_reg(2'd3, 32'h0);
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_regs();
        test_continuous();
        test_one_shot();
        test_cadence();
        test_back_to_back();
        test_freq_change();
`ifdef BUZZER_TONE_IRQ_EN
        test_irq();
`endif
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout sim_time=%0t limit=200000", $time);
        $fatal(1, "bench time limit expired");
    end

endmodule
